// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   ST_IDLE/ST_WAIT/ST_RESP : FSM state encodings
//   state_t                 : FSM state type built on those encodings
//   CNT_W                   : latency counter width (LATENCY up to 15)
//   WORD_W                  : data word width
package dmem_pkg;
  localparam int CNT_W  = 4;
  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with a synchronous write and a registered read.
// Ports:
//   clk      : clock
//   i_en     : access enable (one cycle per request)
//   i_we     : 1 = write i_wdata, 0 = read into o_rdata
//   i_idx    : word index
//   i_wdata  : write data
//   o_rdata  : registered read data, holds until the next read
// Contents and the read register are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      else      r_q          <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word load/store at a time, performs
// the access LATENCY cycles after acceptance and holds the response until
// the requester consumes it.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE, not in reset)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address, word index = req_addr[AW+1:2]
//   req_wdata           : store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data, 0 for stores and faults
//   rsp_err             : misaligned access fault
// Optional feature: DMEM_ALIGN_CHECK_EN - when defined, a misaligned address
// suppresses the access and flags rsp_err; otherwise low address bits are
// ignored and rsp_err is always 0.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [AW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;
  logic              r_rsp_valid;
  logic              r_rd_sel;   // response carries RAM read data
  logic              r_err;
  logic              w_fault;
  logic              w_access;
  logic [WORD_W-1:0] w_q;

  // Address bits above the index alias; low bits only matter for the fault check.
  logic w_unused_addr;
  assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_misal;
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) r_misal <= (req_addr[1:0] != 2'b00);
  end
  assign w_fault = r_misal;
`else
  assign w_fault = 1'b0;
`endif

  assign req_ready = (r_state == S_IDLE) && !reset;
  // Gated by reset so an aborted store never reaches the (unreset) RAM.
  assign w_access  = (r_state == S_WAIT) && (r_cnt == '0) && !reset;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .i_en    (w_access && !w_fault),
    .i_we    (r_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_idx   <= req_addr[AW+1:2];
            r_wdata <= req_wdata;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rd_sel    <= !r_we && !w_fault;
            r_err       <= w_fault;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Selection flag and read register both hold, so rdata persists after consume.
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rd_sel ? w_q : '0;
  assign rsp_err   = r_err;
endmodule
